// File: rtl/fpadd_issue_ctrl.sv
// Valid/ready sequencing front end for the FP32 adder datapath on fpbus.
// Issues an operand pair, waits the fixed latency, then registers the result and its class flags.
module fpadd_issue_ctrl #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      bus_a,
    output logic [31:0]      bus_b,
    input  logic [31:0]      bus_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_nan,
    output logic             out_inf,
    output logic             out_zero,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       release_hs;
    logic [7:0] res_exp;
    logic       res_man_nz;

    assign accept     = in_valid && in_ready;
    assign capture    = (state == WAIT) && (cnt == 4'd1);
    assign release_hs = (state == DONE) && out_ready;
    assign res_exp    = bus_result[30:23];
    assign res_man_nz = |bus_result[22:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In DONE the slot frees the same cycle the consumer takes the result.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:    in_ready = !rst;
            WAIT:    in_ready = 1'b0;
            DONE: begin
                in_ready  = !rst && out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_a <= '0;
            bus_b <= '0;
            cnt   <= '0;
        end else if (accept) begin
            bus_a <= in_a;
            bus_b <= in_b;
            cnt   <= LAT;
        end else if (state == WAIT && !capture) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Flags are taken from the same bus sample as the result so they stay coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_nan    <= 1'b0;
            out_inf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (capture) begin
            out_result <= bus_result;
            out_nan    <= (res_exp == 8'hFF) && res_man_nz;
            out_inf    <= (res_exp == 8'hFF) && !res_man_nz;
            out_zero   <= (res_exp == 8'h00) && !res_man_nz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             ops_done <= '0;
        else if (release_hs) ops_done <= ops_done + CNT_W'(1);
    end

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Directed bench for fpadd_issue_ctrl: one L=1/CNT_W=4 instance and one L=4 instance.
// The fpbus adder is modelled by a small sum table (combinational for L=1, 3-deep pipe for L=4).
module tb_fpadd_issue_ctrl;

    logic        clk;
    logic        rst1, rst4;
    logic        in_valid1, in_valid4;
    logic        in_ready1, in_ready4;
    logic [31:0] in_a1, in_b1, in_a4, in_b4;
    logic [31:0] bus_a1, bus_b1, bus_a4, bus_b4;
    logic [31:0] bus_result1, bus_result4;
    logic        out_valid1, out_valid4;
    logic        out_ready1, out_ready4;
    logic [31:0] out_result1, out_result4;
    logic        out_nan1, out_inf1, out_zero1;
    logic        out_nan4, out_inf4, out_zero4;
    logic        busy1, busy4;
    logic [3:0]  ops_done1;
    logic [15:0] ops_done4;
    logic [31:0] p1, p2, p3;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] k;
        k = {a, b};
        case (k)
            64'h3F800000_40000000: fsum = 32'h40400000;
            64'h40000000_40000000: fsum = 32'h40800000;
            64'h7FC00000_3F800000: fsum = 32'h7FC00000;
            64'h7F800000_7F800000: fsum = 32'h7F800000;
            64'h3F800000_BF800000: fsum = 32'h00000000;
            default:               fsum = 32'h7F7FFFFF;
        endcase
    endfunction

    assign bus_result1 = fsum(bus_a1, bus_b1);
    assign bus_result4 = p3;

    always @(posedge clk) begin
        p1 <= fsum(bus_a4, bus_b4);
        p2 <= p1;
        p3 <= p2;
    end

    fpadd_issue_ctrl #(.LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1),
        .bus_a(bus_a1), .bus_b(bus_b1), .bus_result(bus_result1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1),
        .out_nan(out_nan1), .out_inf(out_inf1), .out_zero(out_zero1),
        .busy(busy1), .ops_done(ops_done1)
    );

    fpadd_issue_ctrl #(.LATENCY(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4),
        .bus_a(bus_a4), .bus_b(bus_b4), .bus_result(bus_result4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_result(out_result4),
        .out_nan(out_nan4), .out_inf(out_inf4), .out_zero(out_zero4),
        .busy(busy4), .ops_done(ops_done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b1; rst4 = 1'b1;
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        in_a1 = '0; in_b1 = '0; in_a4 = '0; in_b4 = '0;
        out_ready1 = 1'b0; out_ready4 = 1'b0;
        step();
        step();
        chk("rst_in_ready1", 32'(in_ready1), 32'd0);
        chk("rst_in_ready4", 32'(in_ready4), 32'd0);
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_bus_a", bus_a1, 32'h0);
        chk("rst_out_result", out_result1, 32'h0);
        chk("rst_ops_done", 32'(ops_done1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        rst1 = 1'b0; rst4 = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready1), 32'd1);

        // T1: 1.0 + 2.0 at L=1, first edge after reset
        in_valid1 = 1'b1; in_a1 = 32'h3F800000; in_b1 = 32'h40000000;
        out_ready1 = 1'b1;
        step();
        chk("t1_bus_a", bus_a1, 32'h3F800000);
        chk("t1_bus_b", bus_b1, 32'h40000000);
        chk("t1_busy", 32'(busy1), 32'd1);
        chk("t1_wait_ready", 32'(in_ready1), 32'd0);
        chk("t1_wait_valid", 32'(out_valid1), 32'd0);
        in_valid1 = 1'b0;
        step();
        chk("t1_valid", 32'(out_valid1), 32'd1);
        chk("t1_result", out_result1, 32'h40400000);
        chk("t1_flags", 32'({out_nan1, out_inf1, out_zero1}), 32'd0);
        chk("t1_done_ready", 32'(in_ready1), 32'd1);
        chk("t1_cnt_pre", 32'(ops_done1), 32'd0);
        step();
        chk("t1_valid_drop", 32'(out_valid1), 32'd0);
        chk("t1_ops_done", 32'(ops_done1), 32'd1);
        chk("t1_idle", 32'(busy1), 32'd0);

        // T2: backpressure with a pending operand pair that must be ignored
        out_ready1 = 1'b0;
        in_valid1 = 1'b1; in_a1 = 32'h40000000; in_b1 = 32'h40000000;
        step();
        in_a1 = 32'h7FC00000; in_b1 = 32'h3F800000;
        step();
        chk("t2_result", out_result1, 32'h40800000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_result", out_result1, 32'h40800000);
            chk("t2_hold_ready", 32'(in_ready1), 32'd0);
            chk("t2_hold_valid", 32'(out_valid1), 32'd1);
            chk("t2_hold_bus_a", bus_a1, 32'h40000000);
        end
        out_ready1 = 1'b1;
        #1;
        chk("t2_comb_ready", 32'(in_ready1), 32'd1);
        step();
        chk("t2_release_valid", 32'(out_valid1), 32'd0);
        chk("t2_release_busy", 32'(busy1), 32'd1);
        chk("t2_ops_done", 32'(ops_done1), 32'd2);
        chk("t2_new_bus_a", bus_a1, 32'h7FC00000);

        // T3/T4: NaN, then back-to-back Inf and signed-zero sums
        in_a1 = 32'h7F800000; in_b1 = 32'h7F800000;
        step();
        chk("t3_result", out_result1, 32'h7FC00000);
        chk("t3_flags", 32'({out_nan1, out_inf1, out_zero1}), 32'h4);
        step();
        chk("t4_b2b_ops", 32'(ops_done1), 32'd3);
        chk("t4_b2b_valid", 32'(out_valid1), 32'd0);
        chk("t4_bus_a", bus_a1, 32'h7F800000);
        in_a1 = 32'h3F800000; in_b1 = 32'hBF800000;
        step();
        chk("t4_inf_result", out_result1, 32'h7F800000);
        chk("t4_inf_flags", 32'({out_nan1, out_inf1, out_zero1}), 32'h2);
        step();
        chk("t4_b2b_ops2", 32'(ops_done1), 32'd4);
        in_valid1 = 1'b0;
        step();
        chk("t4_zero_result", out_result1, 32'h00000000);
        chk("t4_zero_flags", 32'({out_nan1, out_inf1, out_zero1}), 32'h1);
        step();
        chk("t4_ops_done", 32'(ops_done1), 32'd5);
        chk("t4_idle", 32'(busy1), 32'd0);

        // L=4 latency: valid exactly four edges after accept
        in_valid4 = 1'b1; in_a4 = 32'h3F800000; in_b4 = 32'h40000000;
        out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("l4_not_yet", 32'(out_valid4), 32'd0);
        end
        step();
        chk("l4_valid", 32'(out_valid4), 32'd1);
        chk("l4_result", out_result4, 32'h40400000);
        step();
        chk("l4_ops_done", 32'(ops_done4), 32'd1);

        // T5: reset two edges after accept discards the op
        in_valid4 = 1'b1; in_a4 = 32'h40000000; in_b4 = 32'h40000000;
        step();
        in_valid4 = 1'b0;
        step();
        step();
        rst4 = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid4), 32'd0);
        chk("t5_rst_ready", 32'(in_ready4), 32'd0);
        chk("t5_rst_busy", 32'(busy4), 32'd0);
        chk("t5_rst_ops", 32'(ops_done4), 32'd0);
        step();
        rst4 = 1'b0;
        #1;
        chk("t5_ready_after", 32'(in_ready4), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_valid", 32'(out_valid4), 32'd0);
        end
        chk("t5_ops_done", 32'(ops_done4), 32'd0);

        // T6: 17 completions on the 4-bit counter wrap to 1
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        #1;
        chk("t6_rst_ops", 32'(ops_done1), 32'd0);
        out_ready1 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid1 = 1'b1; in_a1 = 32'h3F800000; in_b1 = 32'h40000000;
            step();
            in_valid1 = 1'b0;
            step();
            chk("t6_result", out_result1, 32'h40400000);
            step();
            if (i == 15) chk("t6_wrap_zero", 32'(ops_done1), 32'd0);
        end
        chk("t6_wrap_one", 32'(ops_done1), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
